uart_tx_feeder: RTL and testbench

Byte-buffering front end that sits directly upstream of the UART serializer. Accepts bytes from the host side into a small FIFO, launches them one at a time onto the serializer's data-valid/byte inputs, and paces launches on the serializer's done-level handshake. Isolates bursty producers from the serializer's one-byte-at-a-time acceptance.

---
 rtl/uart_tx_feeder_pkg.sv | 13 +
 rtl/uart_byte_fifo.sv | 51 +++++
 rtl/uart_tx_feeder.sv | 110 +++++++++++
 tb/tb_uart_tx_feeder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared constants and state encoding for the UART transmit feeder
package uart_tx_feeder_pkg;

    localparam int DEFAULT_DEPTH        = 16;
    localparam int DEFAULT_DONE_TIMEOUT = 4096;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_WAIT_DONE = 2'd1;
    localparam state_t S_WAIT_CLR  = 2'd2;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous DEPTH x 8 byte FIFO with level, full/empty and sticky overflow
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_ok;
    logic        rd_ok;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            // A write against a full FIFO is dropped even if a pop frees a slot this cycle.
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte launcher for a UART serializer; UART_TX_FEEDER_TIMEOUT_EN adds a per-phase handshake timeout
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
    input  logic                     i_Clock,
    input  logic                     rst,
    input  logic                     i_Wr_En,
    input  logic [7:0]               i_Wr_Byte,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Level,
    output logic                     o_Overflow,
    output logic                     o_Tx_DV,
    output logic [7:0]               o_Tx_Byte,
    input  logic                     i_Tx_Done,
    output logic                     o_Busy,
    output logic                     o_Timeout
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_feeder: DEPTH must be a power of two >= 2");
    end
    if (DONE_TIMEOUT < 2) begin : g_bad_timeout
        $error("uart_tx_feeder: DONE_TIMEOUT must be >= 2");
    end

    state_t     state;
    state_t     state_next;
    logic       pop;
    logic [7:0] head;
    logic       tmo_abort;

    uart_byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (i_Clock),
        .rst      (rst),
        .wr_en    (i_Wr_En),
        .wr_data  (i_Wr_Byte),
        .rd_en    (pop),
        .rd_data  (head),
        .full     (o_Full),
        .empty    (o_Empty),
        .level    (o_Level),
        .overflow (o_Overflow)
    );

    assign pop    = (state == S_IDLE) && !o_Empty;
    assign o_Busy = (state != S_IDLE);

    // A done level seen while idle is ignored; it is only waited out in S_WAIT_CLR.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!o_Empty) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done)      state_next = S_WAIT_CLR;
                else if (tmo_abort) state_next = S_IDLE;
            end
            S_WAIT_CLR: begin
                if (!i_Tx_Done)     state_next = S_IDLE;
                else if (tmo_abort) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
        end else begin
            state   <= state_next;
            o_Tx_DV <= pop;
            if (pop) o_Tx_Byte <= head;
        end
    end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(DONE_TIMEOUT);

    logic [TW-1:0] phase_cnt;
    logic          timeout_q;

    assign tmo_abort = (state != S_IDLE) && (phase_cnt == TW'(DONE_TIMEOUT - 1));
    assign o_Timeout = timeout_q;

    // Counter restarts on every state change so each handshake phase gets its own budget.
    always_ff @(posedge i_Clock or negedge rst) begin
        if (!rst) begin
            phase_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_next != state)  phase_cnt <= '0;
            else if (state != S_IDLE) phase_cnt <= phase_cnt + 1'b1;
            if (tmo_abort && state_next == S_IDLE) timeout_q <= 1'b1;
        end
    end
`else
    assign tmo_abort = 1'b0;
    assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 4096;
`endif
    localparam int DEPTH = 16;

    logic       i_Clock = 1'b0;
    logic       rst = 1'b0;
    logic       i_Wr_En = 1'b0;
    logic [7:0] i_Wr_Byte = 8'h00;
    logic       o_Full;
    logic       o_Empty;
    logic [4:0] o_Level;
    logic       o_Overflow;
    logic       o_Tx_DV;
    logic [7:0] o_Tx_Byte;
    logic       i_Tx_Done = 1'b0;
    logic       o_Busy;
    logic       o_Timeout;

    int n_cmp = 0;
    int n_err = 0;
    int n_served = 0;
    logic prev_dv = 1'b0;
    logic [7:0] launched[$];

    uart_tx_feeder #(
        .DEPTH(DEPTH),
        .DONE_TIMEOUT(TMO)
    ) dut (
        .i_Clock    (i_Clock),
        .rst        (rst),
        .i_Wr_En    (i_Wr_En),
        .i_Wr_Byte  (i_Wr_Byte),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Level    (o_Level),
        .o_Overflow (o_Overflow),
        .o_Tx_DV    (o_Tx_DV),
        .o_Tx_Byte  (o_Tx_Byte),
        .i_Tx_Done  (i_Tx_Done),
        .o_Busy     (o_Busy),
        .o_Timeout  (o_Timeout)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every launch pulse; two consecutive high samples would be a stretched pulse.
    always @(posedge i_Clock) begin
        #1;
        if (o_Tx_DV) begin
            launched.push_back(o_Tx_Byte);
            check_eq("dv_single", {31'd0, prev_dv}, 32'd0);
        end
        prev_dv = o_Tx_DV;
    end

    task automatic wr(input logic [7:0] b);
        i_Wr_En   = 1'b1;
        i_Wr_Byte = b;
        @(negedge i_Clock);
    endtask

    task automatic serve(input logic [7:0] exp);
        int waited = 0;
        while (launched.size() <= n_served && waited < 40) begin
            @(negedge i_Clock);
            waited++;
        end
        check_eq("launch_seen", {31'd0, launched.size() > n_served}, 32'd1);
        if (launched.size() > n_served) check_eq("launch_byte", {24'd0, launched[n_served]}, {24'd0, exp});
        check_eq("busy_in_hs", {31'd0, o_Busy}, 32'd1);
        i_Tx_Done = 1'b1;
        repeat (3) @(negedge i_Clock);
        check_eq("no_early_launch", launched.size(), n_served + 1);
        i_Tx_Done = 1'b0;
        @(negedge i_Clock);
        n_served++;
    endtask

    initial begin
        int base;
        repeat (3) @(negedge i_Clock);
        check_eq("rst_empty", {31'd0, o_Empty}, 32'd1);
        check_eq("rst_full", {31'd0, o_Full}, 32'd0);
        check_eq("rst_level", {27'd0, o_Level}, 32'd0);
        check_eq("rst_ovf", {31'd0, o_Overflow}, 32'd0);
        check_eq("rst_dv", {31'd0, o_Tx_DV}, 32'd0);
        check_eq("rst_byte", {24'd0, o_Tx_Byte}, 32'd0);
        check_eq("rst_busy", {31'd0, o_Busy}, 32'd0);
        check_eq("rst_tmo", {31'd0, o_Timeout}, 32'd0);
        rst = 1'b1;
        @(negedge i_Clock);

        // Single byte: DV one edge after the FIFO goes non-empty.
        wr(8'hA5);
        i_Wr_En = 1'b0;
        check_eq("sb_empty", {31'd0, o_Empty}, 32'd0);
        check_eq("sb_level", {27'd0, o_Level}, 32'd1);
        check_eq("sb_dv_early", {31'd0, o_Tx_DV}, 32'd0);
        @(negedge i_Clock);
        check_eq("sb_dv", {31'd0, o_Tx_DV}, 32'd1);
        check_eq("sb_byte", {24'd0, o_Tx_Byte}, 32'hA5);
        check_eq("sb_busy", {31'd0, o_Busy}, 32'd1);
        check_eq("sb_popped", {31'd0, o_Empty}, 32'd1);
        @(negedge i_Clock);
        check_eq("sb_dv_low", {31'd0, o_Tx_DV}, 32'd0);
        check_eq("sb_byte_hold", {24'd0, o_Tx_Byte}, 32'hA5);
        i_Tx_Done = 1'b1;
        @(negedge i_Clock);
        check_eq("sb_busy_clr", {31'd0, o_Busy}, 32'd1);
        i_Tx_Done = 1'b0;
        @(negedge i_Clock);
        check_eq("sb_idle", {31'd0, o_Busy}, 32'd0);
        n_served = 1;

        // Burst of four: first pops on the second write, leaving three queued.
        for (int i = 1; i <= 4; i++) wr(8'(i));
        i_Wr_En = 1'b0;
        check_eq("burst_level", {27'd0, o_Level}, 32'd3);
        for (int i = 1; i <= 4; i++) serve(8'(i));
        check_eq("burst_drain", {27'd0, o_Level}, 32'd0);
        check_eq("burst_idle", {31'd0, o_Busy}, 32'd0);

`ifndef UART_TX_FEEDER_TIMEOUT_EN
        // Overflow: 17 writes fill to 16 (one launched), the 18th is dropped.
        for (int i = 0; i < 17; i++) wr(8'(8'h10 + i));
        check_eq("ovf_full", {31'd0, o_Full}, 32'd1);
        check_eq("ovf_level", {27'd0, o_Level}, 32'd16);
        check_eq("ovf_pre", {31'd0, o_Overflow}, 32'd0);
        wr(8'hEE);
        i_Wr_En = 1'b0;
        check_eq("ovf_flag", {31'd0, o_Overflow}, 32'd1);
        check_eq("ovf_level2", {27'd0, o_Level}, 32'd16);
        for (int i = 0; i < 17; i++) serve(8'(8'h10 + i));
        check_eq("ovf_drain", {31'd0, o_Empty}, 32'd1);
        check_eq("ovf_sticky", {31'd0, o_Overflow}, 32'd1);
`endif

        // Done already high: pass straight to S_WAIT_CLR and hold there.
        i_Tx_Done = 1'b1;
        wr(8'h5A);
        i_Wr_En = 1'b0;
        repeat (3) @(negedge i_Clock);
        wr(8'h6B);
        i_Wr_En = 1'b0;
        repeat (2) @(negedge i_Clock);
        check_eq("dh_count", launched.size(), n_served + 1);
        if (launched.size() > n_served) check_eq("dh_byte", {24'd0, launched[n_served]}, 32'h5A);
        check_eq("dh_busy", {31'd0, o_Busy}, 32'd1);
        check_eq("dh_queued", {27'd0, o_Level}, 32'd1);
        i_Tx_Done = 1'b0;
        n_served++;
        serve(8'h6B);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
        // Timeout: done never rises; abort on the 8th edge in S_WAIT_DONE.
        wr(8'hC1);
        wr(8'hC2);
        i_Wr_En = 1'b0;
        base = n_served;
        check_eq("tmo_launch", launched.size(), base + 1);
        repeat (7) @(negedge i_Clock);
        check_eq("tmo_before", {31'd0, o_Timeout}, 32'd0);
        @(negedge i_Clock);
        check_eq("tmo_flag", {31'd0, o_Timeout}, 32'd1);
        check_eq("tmo_idle", {31'd0, o_Busy}, 32'd0);
        n_served++;
        serve(8'hC2);
        check_eq("tmo_sticky", {31'd0, o_Timeout}, 32'd1);
`else
        check_eq("tmo_tied", {31'd0, o_Timeout}, 32'd0);
`endif

        // Reset mid-handshake with three bytes still queued.
        for (int i = 0; i < 4; i++) wr(8'(8'h31 + i));
        i_Wr_En = 1'b0;
        check_eq("mr_level", {27'd0, o_Level}, 32'd3);
        check_eq("mr_busy", {31'd0, o_Busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("mr_empty", {31'd0, o_Empty}, 32'd1);
        check_eq("mr_lvl0", {27'd0, o_Level}, 32'd0);
        check_eq("mr_busy0", {31'd0, o_Busy}, 32'd0);
        check_eq("mr_dv0", {31'd0, o_Tx_DV}, 32'd0);
        check_eq("mr_byte0", {24'd0, o_Tx_Byte}, 32'd0);
        check_eq("mr_tmo0", {31'd0, o_Timeout}, 32'd0);
        @(negedge i_Clock);
        rst = 1'b1;
        n_served++;
        base = launched.size();
        repeat (10) @(negedge i_Clock);
        check_eq("mr_no_dv", launched.size(), base);
        wr(8'h77);
        i_Wr_En = 1'b0;
        serve(8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
